// File: rtl/vga_copper.sv
// vga_copper: Wishbone write master that replays a programmed command list
// into the display core, one transaction in flight at a time.
//
// Ports:
//   clk, reset          sole clock; synchronous active-high reset
//   prog_we/addr/data   command RAM write port (ignored while busy)
//                       entry = {op[40], offset[39:32], data[31:0]}, op 1 = delay
//   start, stop         begin at entry 0 / abort to IDLE (stop wins)
//   loop_en, end_index  restart after end_index when loop_en is set
//   busy, done          not-idle flag / one-cycle normal-completion pulse
//   cmd_index           entry currently executing
//   wb_*                classic Wishbone write master
module vga_copper #(
   parameter int unsigned DEPTH     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0400_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        prog_we,
   input  logic [4:0]  prog_addr,
   input  logic [40:0] prog_data,
   input  logic        start,
   input  logic        stop,
   input  logic        loop_en,
   input  logic [4:0]  end_index,
   output logic        busy,
   output logic        done,
   output logic [4:0]  cmd_index,
   output logic [31:0] wb_addr_o,
   output logic [31:0] wb_data_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic        wb_ack_i
);

   localparam int unsigned IDX_W   = 5;
   localparam int unsigned ENTRY_W = 41;
   localparam int unsigned CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH    = 2'd1,
      WAIT_ACK = 2'd2,
      DELAY    = 2'd3
   } state_t;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [ENTRY_W-1:0] rd_data;

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   idx_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               done_nxt;
   logic               entry_end;
   logic               bus_nxt;

   // Command RAM; reading at the next index makes the entry valid during FETCH
   always_ff @(posedge clk) begin
      if (prog_we && !busy) begin
         mem[prog_addr] <= prog_data;
      end
      rd_data <= mem[idx_nxt];
   end

   // Next-state, next-index and delay-counter logic
   always_comb begin
      state_nxt = state;
      idx_nxt   = cmd_index;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      entry_end = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FETCH;
               idx_nxt   = '0;
            end
         end
         FETCH: begin
            if (rd_data[40]) begin
               state_nxt = DELAY;
               cnt_nxt   = rd_data[15:0];
            end else begin
               state_nxt = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (wb_ack_i) begin
               entry_end = 1'b1;
            end
         end
         DELAY: begin
            if (cnt == '0) begin
               entry_end = 1'b1;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Entry finished: advance, wrap for looping, or finish
      if (entry_end) begin
         if (cmd_index != end_index) begin
            state_nxt = FETCH;
            idx_nxt   = cmd_index + IDX_W'(1);
         end else if (loop_en) begin
            state_nxt = FETCH;
            idx_nxt   = '0;
         end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
      end

      // Abort overrides everything, including a same-cycle ack or start
      if (stop) begin
         state_nxt = IDLE;
         done_nxt  = 1'b0;
         cnt_nxt   = '0;
      end
   end

   assign bus_nxt = (state_nxt == WAIT_ACK);

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cmd_index <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         wb_cyc_o  <= 1'b0;
         wb_stb_o  <= 1'b0;
         wb_we_o   <= 1'b0;
         wb_sel_o  <= 4'h0;
         wb_addr_o <= '0;
         wb_data_o <= '0;
      end else begin
         state     <= state_nxt;
         cmd_index <= idx_nxt;
         cnt       <= cnt_nxt;
         busy      <= (state_nxt != IDLE);
         done      <= done_nxt;
         wb_cyc_o  <= bus_nxt;
         wb_stb_o  <= bus_nxt;
         wb_we_o   <= bus_nxt;
         wb_sel_o  <= bus_nxt ? 4'hF : 4'h0;
         // Address/data latched once on entry so they stay stable until ack
         if (state == FETCH && bus_nxt) begin
            wb_addr_o <= BASE_ADDR | {24'h0, rd_data[39:32]};
            wb_data_o <= rd_data[31:0];
         end
      end
   end

endmodule

// File: tb/tb_vga_copper.sv
// tb_vga_copper: directed, table-driven bench for vga_copper with a small
// Wishbone slave model and a bus monitor that logs completed writes.
module tb_vga_copper;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        prog_we = 1'b0;
   logic [4:0]  prog_addr = '0;
   logic [40:0] prog_data = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop_en = 1'b0;
   logic [4:0]  end_index = '0;
   logic        busy;
   logic        done;
   logic [4:0]  cmd_index;
   logic [31:0] wb_addr_o;
   logic [31:0] wb_data_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic        wb_ack_i = 1'b0;

   always #5 clk = ~clk;

   vga_copper dut (
      .clk       (clk),
      .reset     (reset),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .start     (start),
      .stop      (stop),
      .loop_en   (loop_en),
      .end_index (end_index),
      .busy      (busy),
      .done      (done),
      .cmd_index (cmd_index),
      .wb_addr_o (wb_addr_o),
      .wb_data_o (wb_data_o),
      .wb_sel_o  (wb_sel_o),
      .wb_we_o   (wb_we_o),
      .wb_stb_o  (wb_stb_o),
      .wb_cyc_o  (wb_cyc_o),
      .wb_ack_i  (wb_ack_i)
   );

   // Slave: registered ack after ack_wait extra stb cycles; sticky mode
   // mirrors stb one cycle late (leaves a stale ack); force_ack acks blindly.
   int ack_wait = 0;
   int stall = 0;
   bit sticky = 1'b0;
   bit force_ack = 1'b0;

   always @(posedge clk) begin
      if (force_ack) begin
         wb_ack_i <= 1'b1;
      end else if (sticky) begin
         wb_ack_i <= wb_stb_o;
      end else if (wb_stb_o && !wb_ack_i) begin
         if (stall >= ack_wait) begin
            wb_ack_i <= 1'b1;
            stall    <= 0;
         end else begin
            wb_ack_i <= 1'b0;
            stall    <= stall + 1;
         end
      end else begin
         wb_ack_i <= 1'b0;
      end
   end

   // Bus monitor
   int          cyc_n = 0;
   int          wr_n = 0;
   int          stb_cyc = 0;
   int          b2b = 0;
   int          unstable = 0;
   int          split = 0;
   int          done_n = 0;
   int          ack_cyc = 0;
   int          done_cyc = 0;
   logic [31:0] wr_addr [64];
   logic [31:0] wr_data [64];
   logic        p_stb = 1'b0;
   logic        p_ack = 1'b0;
   logic [31:0] p_addr = '0;
   logic [31:0] p_data = '0;

   always @(posedge clk) begin
      cyc_n  <= cyc_n + 1;
      p_stb  <= wb_stb_o && wb_cyc_o;
      p_ack  <= wb_ack_i;
      p_addr <= wb_addr_o;
      p_data <= wb_data_o;
      if (wb_stb_o !== wb_cyc_o && !reset && busy === 1'b1) split <= split + 1;
      if (wb_stb_o && wb_cyc_o) begin
         stb_cyc <= stb_cyc + 1;
         if (p_stb && p_ack) b2b <= b2b + 1;
         if (p_stb && !p_ack && (wb_addr_o != p_addr || wb_data_o != p_data ||
                                 !wb_we_o || wb_sel_o != 4'hF))
            unstable <= unstable + 1;
         if (wb_ack_i) begin
            if (wr_n < 64) begin
               wr_addr[wr_n] <= wb_addr_o;
               wr_data[wr_n] <= wb_data_o;
            end
            wr_n    <= wr_n + 1;
            ack_cyc <= cyc_n;
         end
      end
      if (done) begin
         done_n   <= done_n + 1;
         done_cyc <= cyc_n;
      end
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic prog(input logic [4:0] a, input logic op, input logic [7:0] off,
                       input logic [31:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = {op, off, d};
      tick(1);
      prog_we   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while (busy && k < budget) begin
         tick(1);
         k++;
      end
      chk(name, 32'(busy), 32'd0);
      tick(2);
   endtask

   typedef struct {
      logic [7:0]  off;
      logic [31:0] data;
      int          wait_n;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      int          exp_stb;
   } vec_t;

   vec_t vecs [4];
   int   b_wr, b_stb, b_done, b_unst, b_b2b, k;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h08, 32'h0040_0000, 0, 32'h0400_0008, 32'h0040_0000, 2};
      vecs[1] = '{8'h1C, 32'hDEAD_BEEF, 3, 32'h0400_001C, 32'hDEAD_BEEF, 5};
      vecs[2] = '{8'hFF, 32'h0000_0001, 1, 32'h0400_00FF, 32'h0000_0001, 3};
      vecs[3] = '{8'h00, 32'hFFFF_FFFF, 0, 32'h0400_0000, 32'hFFFF_FFFF, 2};

      // Reset state
      reset = 1'b1;
      tick(3);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_index", 32'(cmd_index), 0);
      chk("rst_cyc", 32'(wb_cyc_o), 0);
      chk("rst_stb", 32'(wb_stb_o), 0);
      chk("rst_we", 32'(wb_we_o), 0);
      chk("rst_sel", 32'(wb_sel_o), 0);
      reset = 1'b0;
      tick(1);

      // Ack while idle must be ignored
      force_ack = 1'b1;
      tick(3);
      chk("idle_ack_busy", 32'(busy), 0);
      chk("idle_ack_cyc", 32'(wb_cyc_o), 0);
      force_ack = 1'b0;
      tick(2);

      // Single-write vectors with varying slave wait states
      for (int i = 0; i < 4; i++) begin
         b_wr = wr_n; b_stb = stb_cyc; b_done = done_n;
         prog(5'd0, 1'b0, vecs[i].off, vecs[i].data);
         end_index = 5'd0;
         loop_en   = 1'b0;
         ack_wait  = vecs[i].wait_n;
         pulse_start();
         chk("fetch_busy", 32'(busy), 1);
         chk("fetch_stb", 32'(wb_stb_o), 0);
         tick(1);
         chk("lat_stb", 32'(wb_stb_o), 1);
         chk("lat_sel", 32'(wb_sel_o), 32'hF);
         wait_idle("vec_idle", 50);
         chk("vec_nwr", 32'(wr_n - b_wr), 1);
         chk("vec_addr", wr_addr[b_wr], vecs[i].exp_addr);
         chk("vec_data", wr_data[b_wr], vecs[i].exp_data);
         chk("vec_stbcyc", 32'(stb_cyc - b_stb), 32'(vecs[i].exp_stb));
         chk("vec_done", 32'(done_n - b_done), 1);
         chk("vec_done_lat", 32'(done_cyc), 32'(ack_cyc + 1));
      end
      ack_wait = 0;

      // Three writes with sticky ack: stale ack ignored, gap between strobes
      b_wr = wr_n; b_done = done_n; b_b2b = b2b;
      prog(5'd0, 1'b0, 8'h10, 32'h1111_1111);
      prog(5'd1, 1'b0, 8'h14, 32'h2222_2222);
      prog(5'd2, 1'b0, 8'h18, 32'h3333_3333);
      end_index = 5'd2;
      sticky = 1'b1;
      pulse_start();
      wait_idle("seq3_idle", 60);
      sticky = 1'b0;
      tick(2);
      chk("seq3_nwr", 32'(wr_n - b_wr), 3);
      chk("seq3_a0", wr_addr[b_wr], 32'h0400_0010);
      chk("seq3_a1", wr_addr[b_wr+1], 32'h0400_0014);
      chk("seq3_a2", wr_addr[b_wr+2], 32'h0400_0018);
      chk("seq3_d1", wr_data[b_wr+1], 32'h2222_2222);
      chk("seq3_gap", 32'(b2b - b_b2b), 0);
      chk("seq3_done", 32'(done_n - b_done), 1);

      // Delay entry of 5 (upper half ignored) then a write
      b_wr = wr_n;
      prog(5'd0, 1'b1, 8'h00, 32'h00AB_0005);
      prog(5'd1, 1'b0, 8'h1C, 32'hCAFE_0001);
      end_index = 5'd1;
      pulse_start();
      k = 1;
      while (!wb_cyc_o && k < 40) begin
         tick(1);
         k++;
      end
      chk("delay_gap", 32'(k), 9);
      wait_idle("delay_idle", 40);
      chk("delay_nwr", 32'(wr_n - b_wr), 1);
      chk("delay_addr", wr_addr[b_wr], 32'h0400_001C);

      // Stalled write held 100 cycles, then aborted
      b_wr = wr_n; b_done = done_n; b_unst = unstable;
      prog(5'd0, 1'b0, 8'h18, 32'h5555_AAAA);
      end_index = 5'd0;
      ack_wait = 1000;
      pulse_start();
      tick(1);
      chk("stall_stb0", 32'(wb_stb_o), 1);
      b_stb = stb_cyc;
      tick(100);
      chk("stall_cyc", 32'(wb_cyc_o), 1);
      chk("stall_stb", 32'(wb_stb_o), 1);
      chk("stall_addr", wb_addr_o, 32'h0400_0018);
      chk("stall_cnt", 32'(stb_cyc - b_stb), 100);
      chk("stall_stable", 32'(unstable - b_unst), 0);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk("stop_cyc", 32'(wb_cyc_o), 0);
      chk("stop_stb", 32'(wb_stb_o), 0);
      chk("stop_busy", 32'(busy), 0);
      tick(3);
      chk("stop_nodone", 32'(done_n - b_done), 0);
      chk("stop_nwr", 32'(wr_n - b_wr), 0);
      ack_wait = 0;

      // Looping 0,1,0,1,... then loop_en cleared
      b_wr = wr_n; b_done = done_n;
      prog(5'd0, 1'b0, 8'h10, 32'h0000_00A0);
      prog(5'd1, 1'b0, 8'h14, 32'h0000_00A1);
      end_index = 5'd1;
      loop_en = 1'b1;
      pulse_start();
      k = 0;
      while ((wr_n - b_wr) < 5 && k < 200) begin
         tick(1);
         k++;
      end
      loop_en = 1'b0;
      wait_idle("loop_idle", 60);
      chk("loop_nwr", 32'(wr_n - b_wr), 6);
      for (int i = 0; i < 6; i++)
         chk("loop_addr", wr_addr[b_wr+i], (i % 2 == 0) ? 32'h0400_0010 : 32'h0400_0014);
      chk("loop_done", 32'(done_n - b_done), 1);

      // Reset during WAIT_ACK
      prog(5'd0, 1'b0, 8'h20, 32'h1234_5678);
      end_index = 5'd0;
      ack_wait = 1000;
      pulse_start();
      tick(1);
      chk("rwa_stb", 32'(wb_stb_o), 1);
      reset = 1'b1;
      tick(1);
      chk("rwa_cyc", 32'(wb_cyc_o), 0);
      chk("rwa_stb_lo", 32'(wb_stb_o), 0);
      chk("rwa_busy", 32'(busy), 0);
      chk("rwa_index", 32'(cmd_index), 0);
      reset = 1'b0;
      tick(1);

      // Programming while busy is ignored; rerun shows original entry
      pulse_start();
      tick(1);
      prog(5'd0, 1'b0, 8'h24, 32'hBAD0_BAD0);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      ack_wait = 0;
      tick(1);
      b_wr = wr_n;
      pulse_start();
      wait_idle("rerun_idle", 40);
      chk("rerun_nwr", 32'(wr_n - b_wr), 1);
      chk("rerun_addr", wr_addr[b_wr], 32'h0400_0020);
      chk("rerun_data", wr_data[b_wr], 32'h1234_5678);
      chk("cyc_stb_split", 32'(split), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_copper.md
VGA_COPPER -- requirements
Module: vga_copper

Interface
REQ-001 Parameter: DEPTH, 32, number of command entries (index width 5).
REQ-002 Parameter: BASE_ADDR, 32'h0400_0000, Wishbone base for the display core.
REQ-003 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high.
REQ-005 Port: prog_we  in  1  command RAM write strobe.
REQ-006 Port: prog_addr  in  5  command RAM entry index.
REQ-007 Port: prog_data  in  41  entry: [40]=op (0 write, 1 delay), [39:32]=register offset, [31:0]=data.
REQ-008 Port: start  in  1  pulse; begin execution at entry 0.
REQ-009 Port: stop  in  1  pulse; abort execution.
REQ-010 Port: loop_en  in  1  after last entry, restart at entry 0.
REQ-011 Port: end_index  in  5  index of last entry to execute.
REQ-012 Port: busy  out  1  high in any state other than IDLE.
REQ-013 Port: done  out  1  one-cycle pulse on normal completion.
REQ-014 Port: cmd_index  out  5  index of entry currently executing.
REQ-015 Port: wb_addr_o, wb_data_o  out  32 each; wb_sel_o  out  4; wb_we_o, wb_stb_o, wb_cyc_o  out  1 each.
REQ-016 Port: wb_ack_i  in  1  slave acknowledge.

Function
REQ-017 The block is a Wishbone write master that replays a programmed list of register writes into the display core, one transaction in flight at a time.
REQ-018 Command RAM: DEPTH x 41, synchronous write on prog_we only when busy=0; prog_we while busy=1 is ignored; read is synchronous with one-cycle latency.
REQ-019 States: IDLE, FETCH, WAIT_ACK, DELAY.
REQ-020 IDLE: start=1 and stop=0 -> FETCH with cmd_index=0; start while busy is ignored.
REQ-021 FETCH (exactly 1 cycle): RAM read of cmd_index; next state WAIT_ACK if op=0, DELAY if op=1.
REQ-022 WAIT_ACK: wb_cyc_o=wb_stb_o=wb_we_o=1, wb_sel_o=4'hF, wb_addr_o=BASE_ADDR | {24'h0, offset}, wb_data_o=entry data; all hold stable until ack.
REQ-023 wb_ack_i is honoured only in WAIT_ACK; ack in any other state is ignored (covers stale ack from the slave's registered handshake).
REQ-024 On ack: cyc/stb/we drop on the next edge; the block never asserts stb in two consecutive cycles across transactions (FETCH forms the mandatory idle gap).
REQ-025 Stalling writes (wait-for-condition) hold WAIT_ACK indefinitely; no timeout.
REQ-026 DELAY: lasts data[15:0]+1 cycles with no bus activity; data[31:16] is ignored.
REQ-027 Entry completion (ack or end of delay): if cmd_index != end_index -> FETCH at cmd_index+1; else if loop_en -> FETCH at 0; else -> IDLE with done=1 for one cycle.
REQ-028 cmd_index increments modulo 32; end_index beyond the programmed range simply executes stale entries.
REQ-029 loop_en is sampled at completion of the last entry only.
REQ-030 stop=1 in any state -> IDLE on the next edge, cyc/stb low, no done pulse; stop wins over simultaneous start or ack.
REQ-031 Outside WAIT_ACK: cyc=stb=we=0; wb_addr_o/wb_data_o are don't-care.
REQ-032 Latency: start sampled at edge t -> stb high in cycle t+2; final ack in cycle a -> done high in cycle a+1.

Reset
REQ-033 reset=1 -> state IDLE, busy=0, done=0, cmd_index=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, delay counter 0, effective on the next edge including mid-transaction.
REQ-034 Command RAM contents are not cleared by reset.

Verification
REQ-035 Program entry0={0,08,0x0040_0000}, end_index=0, loop_en=0, start; slave acks 1 cycle after stb -> one write to 0x0400_0008, stb high exactly 2 cycles, done pulse once, busy low after.
REQ-036 Entries 0..2 writes, end_index=2; slave holds ack high while stb high -> exactly 3 transactions, a stb-low gap of at least 1 cycle between each, stale ack ignored.
REQ-037 Entry0 delay data=5, entry1 write 0x1C, end_index=1 -> no cyc for 6 cycles after FETCH, then one write.
REQ-038 Entry0 write to 0x18 with ack withheld 100 cycles -> stb/cyc held stable 100 cycles; then stop -> cyc low next edge, no done.
REQ-039 loop_en=1, end_index=1 -> writes cycle 0,1,0,1...; clear loop_en -> terminates after entry1 with done.
REQ-040 reset asserted in WAIT_ACK -> cyc/stb low next edge, busy=0; prog_we while busy has no effect (read back by rerun).
